alu_exec_stage: RTL
===================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
REQ-002 The block SHALL provide these upstream (decode-side) ports:
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept.
- in_opcode  input  6  000000 AND, 000001 ADD, 000010 SUB, 000011 ANDI, 000100 ADDI.
- in_rs1  input  32  source 1 data.
- in_rs2  input  32  source 2 data, used by R-type.
- in_imm  input  16  immediate, used by I-type.
- in_rd  input  5  destination register.
REQ-003 The block SHALL provide these ports to the external combinational ALU instance:
- alu_a  output  32  operand A.
- alu_b  output  32  operand B.
- alu_op  output  6  opcode.
- alu_result  input  32.
- alu_carry, alu_zero, alu_negative, alu_overflow  input  1 each.
REQ-004 The block SHALL provide these downstream (writeback-side) ports:
- out_valid  output  1.
- out_ready  input  1.
- out_result  output  32.
- out_rd  output  5.
- out_flags  output  4  {C,Z,N,V} of this instruction.
- out_illegal  output  1  opcode was not one of the five defined.
- status_flags  output  4  architectural {C,Z,N,V}.
- retire_count  output  16  instructions popped.

Function
REQ-005 alu_a SHALL equal in_rs1 and alu_op SHALL equal in_opcode, combinationally.
REQ-006 alu_b SHALL be selected per opcode:
- in_rs2 for 000000, 000001 and 000010.
- in_imm zero-extended for 000011 (ANDI).
- in_imm sign-extended for 000100 (ADDI).
- 32'h0 otherwise.
REQ-007 Output buffering SHALL be a 2-entry FIFO of {result, rd, flags, illegal}, with occupancy count 0..2.
REQ-008 in_ready SHALL be 1 when count<2, independent of out_ready.
REQ-009 A push SHALL occur when in_valid&in_ready; the entry captures alu_result and the flags in the same cycle.
REQ-010 A pop SHALL occur when out_valid&out_ready; out_valid SHALL be 1 exactly when count>0.
REQ-011 out_* SHALL present the oldest entry and SHALL hold stable while out_valid&~out_ready.
REQ-012 Latency: an instruction accepted at edge N into an empty FIFO SHALL show out_valid=1 after edge N.
REQ-013 A simultaneous push and pop at count 1 SHALL leave count at 1 and preserve order. At count 2 no push occurs; a pop alone yields count 1.
REQ-014 Entry flags for ADD/SUB/ADDI SHALL be the ALU C,Z,N,V. For AND/ANDI they SHALL be C=0, V=0, with Z and N from the ALU, because the ALU's C/V are stale for logic ops.
REQ-015 An illegal opcode SHALL push an entry with result 0, flags 0100 and illegal=1.
REQ-016 status_flags SHALL update on push:
- all four bits for ADD/SUB/ADDI.
- Z and N only for AND/ANDI, with C and V held.
- no change for illegal opcodes.
REQ-017 retire_count SHALL increment by 1 per pop and wrap from 16'hFFFF to 0.

Reset
REQ-018 On reset assertion, the block SHALL immediately set count=0, out_valid=0, status_flags=0, retire_count=0, and clear the out_result/out_rd/out_flags/out_illegal registers to 0.
REQ-019 Any in-flight or buffered instruction SHALL be discarded on reset without being counted.
REQ-020 in_ready SHALL be 1 on the first cycle after reset deassertion.

Verification
REQ-021 ADD: rs1=7FFFFFFF, rs2=1, out_ready=1 -> after one edge out_result=80000000, out_flags=0011, status_flags=0011.
REQ-022 ADDI with imm=FFFF, rs1=5 -> alu_b=FFFFFFFF, result=4, C=1. ANDI with imm=FFFF, rs1=12345678 -> alu_b=0000FFFF, result=00005678, status C/V unchanged.
REQ-023 Backpressure: out_ready=0, push three instructions back to back -> in_ready falls after the 2nd push and the 3rd is held. Raising out_ready -> results pop in order, one per cycle, and retire_count reaches 3.
REQ-024 Simultaneous push and pop at count 1 -> count stays 1 and the order is intact. Illegal opcode 111111 -> result 0, illegal=1, status_flags unchanged.
REQ-025 Assert reset while count=2 -> out_valid=0 immediately, retire_count=0, and the buffered entries are never emitted.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage sitting between decode and writeback. It drives an
//   external combinational ALU and buffers the results in a 2-entry FIFO
//   toward writeback. It also keeps the architectural {C,Z,N,V} flags and
//   a count of retired (popped) instructions.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake
//   in_opcode           6-bit opcode (AND, ADD, SUB, ANDI, ADDI)
//   in_rs1/in_rs2       source operands; in_imm is the 16-bit immediate
//   in_rd               destination register
//   alu_a/alu_b/alu_op  operands and opcode sent to the external ALU
//   alu_result, alu_carry/zero/negative/overflow   ALU response
//   out_valid/out_ready writeback-side handshake
//   out_result/out_rd/out_flags/out_illegal   oldest buffered entry
//   status_flags        architectural {C,Z,N,V}
//   retire_count        number of popped instructions (wraps)
module alu_exec_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [15:0] in_imm,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic [3:0]  out_flags,
    output logic        out_illegal,
    output logic [3:0]  status_flags,
    output logic [15:0] retire_count
);

    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ANDI = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b000100;

    logic [31:0] mem_result  [2];
    logic [4:0]  mem_rd      [2];
    logic [3:0]  mem_flags   [2];
    logic        mem_illegal [2];

    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;

    logic        legal;
    logic        logic_op;
    logic [31:0] entry_result;
    logic [3:0]  entry_flags;
    logic        push;
    logic        pop;

    assign alu_a = in_rs1;
    assign alu_op = in_opcode;

    // Operand B selection and opcode classification
    always_comb begin
        alu_b    = 32'h0;
        legal    = 1'b0;
        logic_op = 1'b0;
        case (in_opcode)
            OP_AND: begin
                alu_b    = in_rs2;
                legal    = 1'b1;
                logic_op = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                alu_b = in_rs2;
                legal = 1'b1;
            end
            OP_ANDI: begin
                alu_b    = {16'h0, in_imm};
                legal    = 1'b1;
                logic_op = 1'b1;
            end
            OP_ADDI: begin
                alu_b = {{16{in_imm[15]}}, in_imm};
                legal = 1'b1;
            end
            default: begin
                alu_b = 32'h0;
            end
        endcase
    end

    // The ALU leaves C/V stale on logic ops, so those bits are forced to 0.
    // Illegal opcodes produce a clean zero result with only Z set.
    always_comb begin
        entry_result = alu_result;
        entry_flags  = {alu_carry, alu_zero, alu_negative, alu_overflow};
        if (!legal) begin
            entry_result = 32'h0;
            entry_flags  = 4'b0100;
        end else if (logic_op) begin
            entry_flags = {1'b0, alu_zero, alu_negative, 1'b0};
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_result  = mem_result[rd_ptr];
    assign out_rd      = mem_rd[rd_ptr];
    assign out_flags   = mem_flags[rd_ptr];
    assign out_illegal = mem_illegal[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_result[i]  <= 32'h0;
                mem_rd[i]      <= 5'h0;
                mem_flags[i]   <= 4'h0;
                mem_illegal[i] <= 1'b0;
            end
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            status_flags <= 4'h0;
            retire_count <= 16'h0;
        end else begin
            if (push) begin
                mem_result[wr_ptr]  <= entry_result;
                mem_rd[wr_ptr]      <= in_rd;
                mem_flags[wr_ptr]   <= entry_flags;
                mem_illegal[wr_ptr] <= ~legal;
                wr_ptr              <= ~wr_ptr;
                if (legal) begin
                    if (logic_op) begin
                        status_flags <= {status_flags[3], alu_zero, alu_negative, status_flags[0]};
                    end else begin
                        status_flags <= {alu_carry, alu_zero, alu_negative, alu_overflow};
                    end
                end
            end
            if (pop) begin
                rd_ptr       <= ~rd_ptr;
                retire_count <= retire_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
